// File: rtl/store_commit_drain_unit.sv
// store_commit_drain_unit: drains committed store-queue head entries to the
// DCache through WRITE_PORT_NUM req/ack write ports, releasing SQ entries
// strictly in program order.
// Optional feature macro: STORE_COMMIT_COALESCE_EN (merges slot k+1 into slot k
// when both write the same line; undefined = one write per store).

package store_commit_drain_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } slot_st_e;
endpackage

// Per-slot next-state/payload step, evaluated before the release shift.
module store_commit_drain_slot
  import store_commit_drain_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  slot_st_e                  st_q,
  input  logic                      elig,
  input  logic                      cond_en,
  input  logic                      ack,
  input  logic                      absorb,
  input  logic                      mrg_vld,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic [LINE_WIDTH-1:0]     rd_data,
  input  logic [LINE_WIDTH/8-1:0]   rd_be,
  input  logic [LINE_WIDTH-1:0]     mrg_data,
  input  logic [LINE_WIDTH/8-1:0]   mrg_be,
  input  logic [ADDR_WIDTH-1:0]     cur_addr,
  input  logic [LINE_WIDTH-1:0]     cur_data,
  input  logic [LINE_WIDTH/8-1:0]   cur_be,
  output slot_st_e                  st_nxt,
  output logic [ADDR_WIDTH-1:0]     nxt_addr,
  output logic [LINE_WIDTH-1:0]     nxt_data,
  output logic [LINE_WIDTH/8-1:0]   nxt_be
);
  logic [LINE_WIDTH-1:0] fill_data;

  // Younger merged bytes override this slot's bytes
  always_comb begin
    fill_data = rd_data;
    for (int b = 0; b < LINE_WIDTH/8; b++) begin
      if (mrg_vld && mrg_be[b]) fill_data[b*8 +: 8] = mrg_data[b*8 +: 8];
    end
  end

  // IDLE -> REQ (capture payload) or DONE (no write); REQ -> DONE on ack
  always_comb begin
    st_nxt   = st_q;
    nxt_addr = cur_addr;
    nxt_data = cur_data;
    nxt_be   = cur_be;
    case (st_q)
      S_IDLE: begin
        if (elig) begin
          if (cond_en && !absorb) begin
            st_nxt   = S_REQ;
            nxt_addr = rd_addr;
            nxt_data = fill_data;
            nxt_be   = rd_be | (mrg_vld ? mrg_be : '0);
          end else begin
            st_nxt = S_DONE;
          end
        end
      end
      S_REQ:   if (ack) st_nxt = S_DONE;
      default: ;
    endcase
  end
endmodule

module store_commit_drain_unit
  import store_commit_drain_pkg::*;
#(
  parameter int WRITE_PORT_NUM = 2,
  parameter int COMMIT_WIDTH   = 4,
  parameter int SQ_ENTRY_NUM   = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 128
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  commitStore,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]                     commitStoreNum,
  input  logic [$clog2(SQ_ENTRY_NUM+1)-1:0]                     sqCount,
  output logic [WRITE_PORT_NUM-1:0][$clog2(SQ_ENTRY_NUM)-1:0]   retiredPtr,
  input  logic [WRITE_PORT_NUM-1:0][ADDR_WIDTH-1:0]             retiredAddr,
  input  logic [WRITE_PORT_NUM-1:0][LINE_WIDTH-1:0]             retiredData,
  input  logic [WRITE_PORT_NUM-1:0][LINE_WIDTH/8-1:0]           retiredByteWE,
  input  logic [WRITE_PORT_NUM-1:0]                             retiredCondEnabled,
  output logic [WRITE_PORT_NUM-1:0]                             dcWriteReq,
  input  logic [WRITE_PORT_NUM-1:0]                             dcWriteAck,
  output logic [WRITE_PORT_NUM-1:0][ADDR_WIDTH-1:0]             dcWriteAddr,
  output logic [WRITE_PORT_NUM-1:0][LINE_WIDTH-1:0]             dcWriteData,
  output logic [WRITE_PORT_NUM-1:0][LINE_WIDTH/8-1:0]           dcWriteByteWE,
  output logic                                                  releaseStoreQueueHead,
  output logic [$clog2(WRITE_PORT_NUM+1)-1:0]                   releaseStoreQueueHeadEntryNum,
  output logic                                                  busyInRecovery,
  output logic                                                  overflowErr
);
  localparam int W     = WRITE_PORT_NUM;
  localparam int PTR_W = $clog2(SQ_ENTRY_NUM);
  localparam int CNT_W = $clog2(SQ_ENTRY_NUM+1);
  localparam int NUM_W = $clog2(COMMIT_WIDTH+1);
  localparam int REL_W = $clog2(WRITE_PORT_NUM+1);
  localparam int BE_W  = LINE_WIDTH/8;
  localparam int SUM_W = CNT_W + NUM_W;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] data;
    logic [BE_W-1:0]       be;
  } wr_req_t;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [CNT_W-1:0]      pend_q, pend_d;
  logic                  err_q, err_d;
  slot_st_e              st_q   [W];
  slot_st_e              st_d   [W];
  slot_st_e              st_pre [W];
  wr_req_t [W-1:0]       pl_q, pl_d;
  logic [W-1:0][ADDR_WIDTH-1:0] pre_addr;
  logic [W-1:0][LINE_WIDTH-1:0] pre_data;
  logic [W-1:0][BE_W-1:0]       pre_be;

  logic [W-1:0]          elig;
  logic [W-1:0]          absorb;
  logic [W-1:0]          mrg_vld;
  logic [REL_W-1:0]      rel_cnt;
  logic [SUM_W-1:0]      add_sum, pend_sum;

  // Slot k is backed by SQ entry head+k; it may act once k < pending
  always_comb begin
    for (int k = 0; k < W; k++) begin
      elig[k]       = (pend_q > CNT_W'(k));
      retiredPtr[k] = head_q + PTR_W'(k);
    end
  end

`ifdef STORE_COMMIT_COALESCE_EN
  // Fold slot k+1 into slot k when both issue to the same line this cycle
  always_comb begin
    absorb  = '0;
    mrg_vld = '0;
    for (int k = 0; k < W-1; k++) begin
      if (st_q[k] == S_IDLE && elig[k] && retiredCondEnabled[k] && !absorb[k] &&
          st_q[k+1] == S_IDLE && elig[k+1] && retiredCondEnabled[k+1] &&
          retiredAddr[k] == retiredAddr[k+1]) begin
        absorb[k+1] = 1'b1;
        mrg_vld[k]  = 1'b1;
      end
    end
  end
`else
  assign absorb  = '0;
  assign mrg_vld = '0;
`endif

  for (genvar k = 0; k < W; k++) begin : g_slot
    logic [LINE_WIDTH-1:0] m_data;
    logic [BE_W-1:0]       m_be;
    if (k < W-1) begin : g_nxt
      assign m_data = retiredData[k+1];
      assign m_be   = retiredByteWE[k+1];
    end else begin : g_last
      assign m_data = '0;
      assign m_be   = '0;
    end

    store_commit_drain_slot #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .LINE_WIDTH(LINE_WIDTH)
    ) u_slot (
      .st_q     (st_q[k]),
      .elig     (elig[k]),
      .cond_en  (retiredCondEnabled[k]),
      .ack      (dcWriteAck[k]),
      .absorb   (absorb[k]),
      .mrg_vld  (mrg_vld[k]),
      .rd_addr  (retiredAddr[k]),
      .rd_data  (retiredData[k]),
      .rd_be    (retiredByteWE[k]),
      .mrg_data (m_data),
      .mrg_be   (m_be),
      .cur_addr (pl_q[k].addr),
      .cur_data (pl_q[k].data),
      .cur_be   (pl_q[k].be),
      .st_nxt   (st_pre[k]),
      .nxt_addr (pre_addr[k]),
      .nxt_data (pre_data[k]),
      .nxt_be   (pre_be[k])
    );
  end

  // Release only the unbroken run of DONE slots starting at slot 0
  always_comb begin
    logic run;
    run     = 1'b1;
    rel_cnt = '0;
    for (int k = 0; k < W; k++) begin
      if (run && st_q[k] == S_DONE) rel_cnt = rel_cnt + REL_W'(1);
      else                          run     = 1'b0;
    end
  end

  // Shift surviving slots down by the release count; vacated slots refill IDLE
  always_comb begin
    for (int i = 0; i < W; i++) begin
      st_d[i] = S_IDLE;
      pl_d[i] = '0;
      for (int j = 0; j < W; j++) begin
        if (j == i + int'(rel_cnt)) begin
          st_d[i] = st_pre[j];
          pl_d[i] = '{addr: pre_addr[j], data: pre_data[j], be: pre_be[j]};
        end
      end
    end
  end

  // Pending bookkeeping: commit and release apply together, clamp on overflow
  always_comb begin
    head_d   = head_q + PTR_W'(rel_cnt);
    add_sum  = SUM_W'(pend_q) + (commitStore ? SUM_W'(commitStoreNum) : '0);
    pend_sum = (add_sum > SUM_W'(rel_cnt)) ? add_sum - SUM_W'(rel_cnt) : '0;
    err_d    = err_q;
    if (pend_sum > SUM_W'(sqCount)) begin
      pend_d = sqCount;
      err_d  = 1'b1;
    end else begin
      pend_d = CNT_W'(pend_sum);
    end
  end

  // All drain state; reset abandons any outstanding write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
      pl_q   <= '0;
      for (int k = 0; k < W; k++) st_q[k] <= S_IDLE;
    end else begin
      head_q <= head_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      pl_q   <= pl_d;
      for (int k = 0; k < W; k++) st_q[k] <= st_d[k];
    end
  end

  // Requests and payload come straight from slot flops
  always_comb begin
    for (int k = 0; k < W; k++) begin
      dcWriteReq[k]    = (st_q[k] == S_REQ);
      dcWriteAddr[k]   = pl_q[k].addr;
      dcWriteData[k]   = pl_q[k].data;
      dcWriteByteWE[k] = pl_q[k].be;
    end
    releaseStoreQueueHead         = (rel_cnt != '0);
    releaseStoreQueueHeadEntryNum = rel_cnt;
    busyInRecovery                = (pend_q != '0) | (|dcWriteReq);
    overflowErr                   = err_q;
  end
endmodule

// File: tb/tb_store_commit_drain_unit.sv
// Bench for store_commit_drain_unit: SQ memory model behind retiredPtr,
// write scoreboard, table of drain vectors and hand sequences for latency,
// ordering, failed SC, wrap, overflow and mid-transaction reset.
module tb_store_commit_drain_unit;
  localparam int W  = 2;
  localparam int SQ = 16;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int BW = LW/8;

  logic clk = 1'b0;
  logic rst;
  logic commitStore;
  logic [2:0] commitStoreNum;
  logic [4:0] sqCount;
  logic [W-1:0][3:0]    retiredPtr;
  logic [W-1:0][AW-1:0] retiredAddr;
  logic [W-1:0][LW-1:0] retiredData;
  logic [W-1:0][BW-1:0] retiredByteWE;
  logic [W-1:0]         retiredCondEnabled;
  logic [W-1:0]         dcWriteReq;
  logic [W-1:0]         dcWriteAck;
  logic [W-1:0][AW-1:0] dcWriteAddr;
  logic [W-1:0][LW-1:0] dcWriteData;
  logic [W-1:0][BW-1:0] dcWriteByteWE;
  logic                 releaseStoreQueueHead;
  logic [1:0]           releaseStoreQueueHeadEntryNum;
  logic                 busyInRecovery;
  logic                 overflowErr;

  store_commit_drain_unit #(
    .WRITE_PORT_NUM(W), .COMMIT_WIDTH(4), .SQ_ENTRY_NUM(SQ),
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .commitStore(commitStore), .commitStoreNum(commitStoreNum), .sqCount(sqCount),
    .retiredPtr(retiredPtr), .retiredAddr(retiredAddr), .retiredData(retiredData),
    .retiredByteWE(retiredByteWE), .retiredCondEnabled(retiredCondEnabled),
    .dcWriteReq(dcWriteReq), .dcWriteAck(dcWriteAck), .dcWriteAddr(dcWriteAddr),
    .dcWriteData(dcWriteData), .dcWriteByteWE(dcWriteByteWE),
    .releaseStoreQueueHead(releaseStoreQueueHead),
    .releaseStoreQueueHeadEntryNum(releaseStoreQueueHeadEntryNum),
    .busyInRecovery(busyInRecovery), .overflowErr(overflowErr)
  );

  always #5 clk = ~clk;

  // SQ storage model
  logic [AW-1:0] sq_addr [SQ];
  logic [LW-1:0] sq_data [SQ];
  logic [BW-1:0] sq_be   [SQ];
  logic          sq_cond [SQ];

  always_comb begin
    for (int k = 0; k < W; k++) begin
      retiredAddr[k]        = sq_addr[retiredPtr[k]];
      retiredData[k]        = sq_data[retiredPtr[k]];
      retiredByteWE[k]      = sq_be[retiredPtr[k]];
      retiredCondEnabled[k] = sq_cond[retiredPtr[k]];
    end
  end

  typedef struct { logic [AW-1:0] a; logic [LW-1:0] d; logic [BW-1:0] b; } wr_t;
  typedef struct { int n; logic [3:0] cond; int ew; int er; } vec_t;

  wr_t  exp_q[$];
  vec_t tbl [8];
  int   total = 0;
  int   bad   = 0;
  int   wr_cnt, rel_cnt, head;
  bit   auto_ack;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One cycle: observe at negedge, check/ack scoreboard writes in program order
  task automatic step();
    wr_t e;
    @(negedge clk);
    for (int k = 0; k < W; k++) begin
      dcWriteAck[k] = 1'b0;
      if (auto_ack && dcWriteReq[k]) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", dcWriteAddr[k], e.a);
          chk("wr_data", dcWriteData[k], e.d);
          chk("wr_be",   dcWriteByteWE[k], e.b);
        end
        dcWriteAck[k] = 1'b1;
        wr_cnt++;
      end
    end
    if (releaseStoreQueueHead) rel_cnt += int'(releaseStoreQueueHeadEntryNum);
  endtask

  task automatic fill(input int n, input logic [3:0] cond, input bit push);
    int p;
    for (int i = 0; i < n; i++) begin
      p = (head + i) % SQ;
      sq_addr[p] = $urandom;
      sq_data[p] = {$urandom, $urandom, $urandom, $urandom};
      sq_be[p]   = 16'($urandom);
      sq_cond[p] = cond[i];
      if (push && cond[i]) exp_q.push_back('{sq_addr[p], sq_data[p], sq_be[p]});
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while ((busyInRecovery || releaseStoreQueueHead || dcWriteReq != '0) && cyc < 60);
    if (cyc >= 60) chk("drain_timeout", 1, 0);
  endtask

  task automatic run_rec(input int n, input logic [3:0] cond, input int ew, input int er, input string nm);
    wr_cnt = 0; rel_cnt = 0; auto_ack = 1'b1;
    fill(n, cond, 1'b1);
    step();
    chk({nm, "_ptr"}, retiredPtr[0], head);
    commitStore = 1'b1; commitStoreNum = 3'(n);
    step();
    commitStore = 1'b0; commitStoreNum = '0;
    drain();
    chk({nm, "_writes"}, wr_cnt, ew);
    chk({nm, "_released"}, rel_cnt, er);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    head = (head + n) % SQ;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 4'b0001, 1, 1};
    tbl[1] = '{2, 4'b0011, 2, 2};
    tbl[2] = '{2, 4'b0010, 1, 2};
    tbl[3] = '{2, 4'b0000, 0, 2};
    tbl[4] = '{4, 4'b1111, 4, 4};
    tbl[5] = '{3, 4'b0101, 2, 3};
    tbl[6] = '{4, 4'b0110, 2, 4};
    tbl[7] = '{1, 4'b0000, 0, 1};

    for (int i = 0; i < SQ; i++) begin
      sq_addr[i] = '0; sq_data[i] = '0; sq_be[i] = '0; sq_cond[i] = 1'b0;
    end
    rst = 1'b1; commitStore = 1'b0; commitStoreNum = '0; sqCount = 5'd16;
    dcWriteAck = '0; auto_ack = 1'b0; head = 0; wr_cnt = 0; rel_cnt = 0;

    // reset state
    step();
    chk("rst_req", dcWriteReq, 0);
    chk("rst_busy", busyInRecovery, 0);
    chk("rst_release", releaseStoreQueueHead, 0);
    chk("rst_err", overflowErr, 0);
    chk("rst_ptr1", retiredPtr[1], 1);
    rst = 1'b0;

    // single store: req at c2, ack at c4, release at c5, idle at c6
    fill(1, 4'b0001, 1'b0);
    step();                                                    // c0
    chk("s1_c0_busy", busyInRecovery, 0);
    commitStore = 1'b1; commitStoreNum = 3'd1;
    step(); commitStore = 1'b0; commitStoreNum = '0;           // c1
    chk("s1_c1_req", dcWriteReq, 0);
    chk("s1_c1_busy", busyInRecovery, 1);
    step();                                                    // c2
    chk("s1_c2_req", dcWriteReq, 2'b01);
    chk("s1_c2_ptr", retiredPtr[0], 0);
    chk("s1_c2_addr", dcWriteAddr[0], sq_addr[0]);
    chk("s1_c2_data", dcWriteData[0], sq_data[0]);
    step();                                                    // c3
    chk("s1_c3_req_held", dcWriteReq, 2'b01);
    chk("s1_c3_be", dcWriteByteWE[0], sq_be[0]);
    step(); dcWriteAck[0] = 1'b1;                              // c4
    chk("s1_c4_release", releaseStoreQueueHead, 0);
    step();                                                    // c5
    chk("s1_c5_req", dcWriteReq, 0);
    chk("s1_c5_release", releaseStoreQueueHead, 1);
    chk("s1_c5_num", releaseStoreQueueHeadEntryNum, 1);
    chk("s1_c5_busy", busyInRecovery, 1);
    step();                                                    // c6
    chk("s1_c6_busy", busyInRecovery, 0);
    chk("s1_c6_release", releaseStoreQueueHead, 0);
    head = 1;

    // parallel drain, out-of-order ack holds release
    fill(2, 4'b0011, 1'b0);
    step(); commitStore = 1'b1; commitStoreNum = 3'd2;         // c0
    step(); commitStore = 1'b0; commitStoreNum = '0;           // c1
    step();                                                    // c2
    chk("p_c2_req", dcWriteReq, 2'b11);
    chk("p_c2_addr0", dcWriteAddr[0], sq_addr[1]);
    chk("p_c2_addr1", dcWriteAddr[1], sq_addr[2]);
    step();                                                    // c3
    chk("p_c3_req_held", dcWriteReq, 2'b11);
    chk("p_c3_data0", dcWriteData[0], sq_data[1]);
    chk("p_c3_data1", dcWriteData[1], sq_data[2]);
    dcWriteAck[1] = 1'b1;
    step();                                                    // c4
    chk("p_c4_req", dcWriteReq, 2'b01);
    chk("p_c4_no_release", releaseStoreQueueHead, 0);
    dcWriteAck[0] = 1'b1;
    step();                                                    // c5
    chk("p_c5_release", releaseStoreQueueHead, 1);
    chk("p_c5_num", releaseStoreQueueHeadEntryNum, 2);
    step();                                                    // c6
    chk("p_c6_busy", busyInRecovery, 0);
    head = 3;

    // failed SC: no request, release two cycles after commit
    fill(1, 4'b0000, 1'b0);
    step(); commitStore = 1'b1; commitStoreNum = 3'd1;         // c0
    step(); commitStore = 1'b0; commitStoreNum = '0;           // c1
    chk("sc_c1_req", dcWriteReq, 0);
    chk("sc_c1_release", releaseStoreQueueHead, 0);
    step();                                                    // c2
    chk("sc_c2_req", dcWriteReq, 0);
    chk("sc_c2_num", releaseStoreQueueHeadEntryNum, 1);
    step();                                                    // c3
    chk("sc_c3_busy", busyInRecovery, 0);
    chk("sc_c3_req", dcWriteReq, 0);
    head = 4;

    // vector table through the scoreboard
    for (int i = 0; i < 8; i++)
      run_rec(tbl[i].n, tbl[i].cond, tbl[i].ew, tbl[i].er, $sformatf("vec%0d", i));

    // advance head to 15
    for (int g = 0; g < SQ && head != 15; g++) run_rec(1, 4'b0001, 1, 1, "pad");

    // wrap: slots straddle entries 15 and 0
    wr_cnt = 0; rel_cnt = 0; auto_ack = 1'b1;
    fill(2, 4'b0011, 1'b1);
    step(); commitStore = 1'b1; commitStoreNum = 3'd2;
    step(); commitStore = 1'b0; commitStoreNum = '0;
    chk("wrap_ptr0", retiredPtr[0], 15);
    chk("wrap_ptr1", retiredPtr[1], 0);
    drain();
    chk("wrap_writes", wr_cnt, 2);
    chk("wrap_released", rel_cnt, 2);
    head = 1;
    step();
    chk("wrap_head_after", retiredPtr[0], 1);

    // overflow: 3 committed with sqCount=1 -> sticky error, only one drains
    wr_cnt = 0; rel_cnt = 0; sqCount = 5'd1;
    fill(3, 4'b0111, 1'b0);
    exp_q.push_back('{sq_addr[head], sq_data[head], sq_be[head]});
    step(); commitStore = 1'b1; commitStoreNum = 3'd3;
    step(); commitStore = 1'b0; commitStoreNum = '0;
    chk("ovf_err", overflowErr, 1);
    drain();
    chk("ovf_writes", wr_cnt, 1);
    chk("ovf_released", rel_cnt, 1);
    chk("ovf_sticky", overflowErr, 1);
    head = 2; sqCount = 5'd16;

    // reset while a request is outstanding
    auto_ack = 1'b0;
    fill(1, 4'b0001, 1'b0);
    step(); commitStore = 1'b1; commitStoreNum = 3'd1;
    step(); commitStore = 1'b0; commitStoreNum = '0;
    step();
    chk("mrst_pre_req", dcWriteReq, 2'b01);
    rst = 1'b1;
    #1;
    chk("mrst_req", dcWriteReq, 0);
    chk("mrst_busy", busyInRecovery, 0);
    chk("mrst_release", releaseStoreQueueHead, 0);
    chk("mrst_err", overflowErr, 0);
    chk("mrst_addr", dcWriteAddr[0], 0);
    step(); rst = 1'b0;
    step();
    chk("mrst_ptr0", retiredPtr[0], 0);
    chk("mrst_ptr1", retiredPtr[1], 1);
    chk("mrst_idle_req", dcWriteReq, 0);
    chk("mrst_idle_busy", busyInRecovery, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_commit_drain_unit.md
Name: store_commit_drain_unit

Overview:
- Multi-port successor to the single-port store committer. Drains committed store-queue (SQ) head entries to the DCache through WRITE_PORT_NUM independent req/ack write ports.
- Releases SQ head entries strictly in program order, and reports recovery-busy while committed stores remain undrained.
- Sits between CommitStage/StoreQueue and the DCache write ports.

Parameters:
- WRITE_PORT_NUM, 2, number of DCache write ports and drain slots (1..4).
- COMMIT_WIDTH, 4, maximum stores committed per cycle.
- SQ_ENTRY_NUM, 16, SQ depth; power of 2, at least WRITE_PORT_NUM.
- ADDR_WIDTH, 32, physical line address width.
- LINE_WIDTH, 128, store block data width; byte-enable width is LINE_WIDTH/8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- commitStore  in  1  commit of committed stores this cycle
- commitStoreNum  in  $clog2(COMMIT_WIDTH+1)  number of stores committed
- sqCount  in  $clog2(SQ_ENTRY_NUM+1)  current SQ occupancy
- retiredPtr  out  WRITE_PORT_NUM x $clog2(SQ_ENTRY_NUM)  SQ read pointer per slot
- retiredAddr  in  WRITE_PORT_NUM x ADDR_WIDTH  line address read from the SQ
- retiredData  in  WRITE_PORT_NUM x LINE_WIDTH  data read from the SQ
- retiredByteWE  in  WRITE_PORT_NUM x LINE_WIDTH/8  byte enables read from the SQ
- retiredCondEnabled  in  WRITE_PORT_NUM  store performs a write (0 = failed SC / cancelled)
- dcWriteReq  out  WRITE_PORT_NUM  write request per port
- dcWriteAck  in  WRITE_PORT_NUM  write accepted by the DCache
- dcWriteAddr/dcWriteData/dcWriteByteWE  out  per port, same widths as the retired* inputs  write payload
- releaseStoreQueueHead  out  1  release SQ head entries
- releaseStoreQueueHeadEntryNum  out  $clog2(WRITE_PORT_NUM+1)  number of entries released
- busyInRecovery  out  1  committed stores are still pending
- overflowErr  out  1  sticky protocol error

Behaviour:
- State:
  - headPtr register, modulo SQ_ENTRY_NUM, reset 0.
  - pending counter, $clog2(SQ_ENTRY_NUM+1) bits, reset 0.
  - Per slot k: state IDLE/REQ/DONE, reset IDLE.
- Slot k always maps to SQ entry headPtr+k, wrapping modulo SQ_ENTRY_NUM. retiredPtr[k] = headPtr+k (combinational).
- Slot k is eligible when k < pending.
- Slot FSM:
  - IDLE, eligible, retiredCondEnabled[k]=1 -> REQ.
  - IDLE, eligible, retiredCondEnabled[k]=0 -> DONE; no request is issued.
  - REQ -> DONE on dcWriteAck[k].
  - DONE -> consumed by release, then re-labelled IDLE.
- dcWriteReq[k] = (state==REQ), registered.
  - Payload is registered on the IDLE->REQ transition and held stable until ack.
  - The request is never withdrawn while waiting for ack.
  - An ack with no outstanding request is ignored.
- Release:
  - releaseStoreQueueHeadEntryNum = count of the leading contiguous DONE slots from slot 0. releaseStoreQueueHead = (count != 0). Both combinational.
  - The same cycle: headPtr += count; pending -= count.
  - The slots shift down by count. Surviving slots keep their state and registered payload.
  - An out-of-order DONE (e.g. slot 1 DONE, slot 0 in REQ) is held and not released.
- pending_next = pending + (commitStore ? commitStoreNum : 0) - released. Commit and release in the same cycle are both applied.
- Latency:
  - Commit at cycle t -> pending updated at t+1 -> dcWriteReq high at t+2 at the earliest.
  - Ack at cycle t -> DONE at t+1 -> release at t+1.
- Overflow: if pending_next > sqCount, set overflowErr (sticky until rst) and clamp pending to sqCount.
- busyInRecovery = (pending != 0) | any slot in REQ.
- rst, including mid-transaction: all outputs deasserted immediately; slots go IDLE; headPtr=0; pending=0; overflowErr=0. Any outstanding DCache request is abandoned.
- headPtr wrap: SQ_ENTRY_NUM-1 + 1 -> 0. Slots straddling the wrap read pointers 15 and 0 (for depth 16).

Optional Feature:
STORE_COMMIT_COALESCE_EN
- Defined:
  - On IDLE->REQ of slot k, a younger IDLE eligible slot j=k+1 merges into k when retiredAddr matches and both have retiredCondEnabled=1.
  - Merged enables = OR of both; bytes enabled in j override k.
  - Slot j goes directly to DONE with no request of its own.
  - Releasing j still waits for k's DONE, so order is preserved.
- Undefined: every entry issues its own write; no address compare logic is present.

Test Plan:
- Single store, 2 ports: commitStoreNum=1 at cycle 0 -> dcWriteReq[0] at cycle 2, retiredPtr[0]=0. Ack at 4 -> release num 1 at 5; busyInRecovery falls at 6.
- Parallel drain: commit 2 with ack held low on both ports -> both requests held with a stable payload. Ack port 1 only -> no release. Ack port 0 -> release num 2 in one cycle.
- Failed SC: commit 1 with retiredCondEnabled=0 -> no dcWriteReq ever; release num 1 two cycles after commit.
- Wrap: headPtr preset to 15 via 15 drained stores, then commit 2 -> retiredPtr = {15,0}. After release, headPtr=1.
- Overflow and reset: sqCount=1, commit 3 -> overflowErr=1 and pending clamps to 1. Asserting rst while dcWriteReq=1 -> all outputs 0 immediately.
- STORE_COMMIT_COALESCE_EN: two stores to 0x40 with WE 0x000F and 0x00F0 -> a single write, WE 0x00FF, then release num 2.
